mod_counter_chain: RTL and testbench

- Parametrised successor to the single-digit 0–9 demo counter.
- A cascade of DIGITS modulo-MODULUS digits, each 4 bits wide, advanced by an internal prescaler tick.
- Single clock domain with a clock-enable tick; no derived clocks.
- Adds up/down counting, synchronous load/clear, count enable and a terminal-count pulse; drives display or decoder logic directly.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/tick_gen.sv | 31 +++
 rtl/mod_counter_chain.sv | 81 ++++++++
 tb/tb_mod_counter_chain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo digit counter and its prescaler.
package counter_pkg;

    localparam int DIGIT_W = 4;

    // Clamp an out-of-range nibble to the top legal digit value.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] value,
                                                     input int modulus);
        if (int'(value) >= modulus)
            return DIGIT_W'(modulus - 1);
        return value;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: asserts step on the enabled cycle that completes TICK_DIV counts.
module tick_gen
    import counter_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_zero,
    output logic step
);

    localparam int PW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    // A synchronous zero request suppresses the step in the same cycle.
    assign step = en & ~sync_zero & (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (sync_zero)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo-MODULUS digits with up/down, load, clear and terminal count.
module mod_counter_chain
    import counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 10,
    parameter int TICK_DIV = 50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        up,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_val,
    output logic [DIGIT_W*DIGITS-1:0]   q,
    output logic                        tick,
    output logic                        tc
);

    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(MODULUS - 1);

    logic [DIGITS-1:0][DIGIT_W-1:0] cnt;
    logic [DIGITS-1:0][DIGIT_W-1:0] cnt_nxt;
    logic [DIGITS-1:0][DIGIT_W-1:0] cnt_ld;
    logic [DIGITS:0]                up_carry;
    logic [DIGITS:0]                dn_borrow;
    logic                           step;
    logic                           wrap;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync_zero (clr | load),
        .step      (step)
    );

    // Bit i says every digit below i is at the rollover value for its direction.
    always_comb begin
        up_carry[0]  = 1'b1;
        dn_borrow[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            up_carry[i+1]  = up_carry[i]  & (cnt[i] == DMAX);
            dn_borrow[i+1] = dn_borrow[i] & (cnt[i] == '0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign cnt_ld[g]  = sat_digit(load_val[g*DIGIT_W +: DIGIT_W], MODULUS);
        assign cnt_nxt[g] = up
            ? (up_carry[g]  ? ((cnt[g] == DMAX) ? '0 : cnt[g] + 1'b1) : cnt[g])
            : (dn_borrow[g] ? ((cnt[g] == '0) ? DMAX : cnt[g] - 1'b1) : cnt[g]);
    end

    assign wrap = up ? up_carry[DIGITS] : dn_borrow[DIGITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            cnt  <= cnt_ld;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else begin
            tick <= step;
            tc   <= step & wrap;
            if (step)
                cnt <= cnt_nxt;
        end
    end

    assign q = cnt;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed bench: decimal 2-digit chain (TICK_DIV=4) and base-6 3-digit chain (TICK_DIV=1).
module tb_mod_counter_chain;

    localparam int NA = 100;
    localparam int NB = 216;
    localparam int TDA = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en = 1'b0, up = 1'b1, clr = 1'b0;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic [7:0]  lv_a = '0;
    logic [11:0] lv_b = '0;
    logic [7:0]  q_a;
    logic [11:0] q_b;
    logic        tick_a, tc_a, tick_b, tc_b;

    int checks = 0;
    int errors = 0;

    int ma_val = 0, ma_pre = 0, mb_val = 0;
    logic ma_tick = 1'b0, ma_tc = 1'b0, mb_tick = 1'b0, mb_tc = 1'b0;

    mod_counter_chain #(.DIGITS(2), .MODULUS(10), .TICK_DIV(TDA)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load_a),
        .load_val(lv_a), .q(q_a), .tick(tick_a), .tc(tc_a)
    );

    mod_counter_chain #(.DIGITS(3), .MODULUS(6), .TICK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load_b),
        .load_val(lv_b), .q(q_b), .tick(tick_b), .tc(tc_b)
    );

    always #5 clk = ~clk;

    // Numeric value of a load word after per-digit saturation.
    function automatic int val_of(input logic [31:0] lv, input int nd, input int m);
        int v, w, nib;
        v = 0;
        w = 1;
        for (int i = 0; i < nd; i++) begin
            nib = int'(lv[4*i +: 4]);
            v += ((nib >= m) ? m - 1 : nib) * w;
            w *= m;
        end
        return v;
    endfunction

    function automatic logic [31:0] q_of(input int v, input int nd, input int m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % m);
            v = v / m;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model A: chain value as an integer modulo 100, prescaler as a plain count.
    always @(posedge clk or negedge reset) begin
        if (!reset || clr) begin
            ma_val <= 0; ma_pre <= 0; ma_tick <= 1'b0; ma_tc <= 1'b0;
        end else if (load_a) begin
            ma_val <= val_of(32'(lv_a), 2, 10); ma_pre <= 0; ma_tick <= 1'b0; ma_tc <= 1'b0;
        end else if (en && ma_pre == TDA - 1) begin
            ma_pre  <= 0;
            ma_tick <= 1'b1;
            ma_val  <= up ? (ma_val + 1) % NA : (ma_val + NA - 1) % NA;
            ma_tc   <= up ? (ma_val == NA - 1) : (ma_val == 0);
        end else begin
            ma_pre  <= en ? ma_pre + 1 : ma_pre;
            ma_tick <= 1'b0;
            ma_tc   <= 1'b0;
        end
    end

    // Model B: every enabled cycle is a step.
    always @(posedge clk or negedge reset) begin
        if (!reset || clr) begin
            mb_val <= 0; mb_tick <= 1'b0; mb_tc <= 1'b0;
        end else if (load_b) begin
            mb_val <= val_of(32'(lv_b), 3, 6); mb_tick <= 1'b0; mb_tc <= 1'b0;
        end else if (en) begin
            mb_tick <= 1'b1;
            mb_val  <= up ? (mb_val + 1) % NB : (mb_val + NB - 1) % NB;
            mb_tc   <= up ? (mb_val == NB - 1) : (mb_val == 0);
        end else begin
            mb_tick <= 1'b0;
            mb_tc   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_q_a",    32'(q_a),    q_of(ma_val, 2, 10));
        chk("model_tick_a", 32'(tick_a), 32'(ma_tick));
        chk("model_tc_a",   32'(tc_a),   32'(ma_tc));
        chk("model_q_b",    32'(q_b),    q_of(mb_val, 3, 6));
        chk("model_tick_b", 32'(tick_b), 32'(mb_tick));
        chk("model_tc_b",   32'(tc_b),   32'(mb_tc));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 20);
        #1;
        chk({name, "_tick_seen"}, 32'(tick_a), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        cyc();
        chk("reset_q_a", 32'(q_a), 32'h0);
        chk("reset_tick_tc", {30'd0, tick_a, tc_a}, 32'h0);
        cyc();
        reset = 1'b1;

        // Async reset mid-count, then first step exactly TICK_DIV cycles later
        lv_a = 8'h37; load_a = 1'b1;
        cyc();
        load_a = 1'b0; en = 1'b1;
        chk("load_37", 32'(q_a), 32'h37);
        cyc();
        reset = 1'b0;
        #1;
        chk("async_rst_q", 32'(q_a), 32'h0);
        chk("async_rst_tick_tc", {30'd0, tick_a, tc_a}, 32'h0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        chk("pre_first_tick", {23'd0, tick_a, q_a}, 32'h000);
        cyc();
        chk("first_tick", {23'd0, tick_a, q_a}, 32'h101);

        // Up-count through the full wrap
        up = 1'b1; lv_a = 8'h98; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        wait_tick("up98");
        chk("up_99", {23'd0, tc_a, q_a}, 32'h099);
        wait_tick("up99");
        chk("up_wrap", {23'd0, tc_a, q_a}, 32'h100);
        lv_a = 8'h09; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        wait_tick("up09");
        chk("up_09_10", {23'd0, tc_a, q_a}, 32'h010);

        // Down-count with borrow and wrap
        up = 1'b0; lv_a = 8'h10; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        wait_tick("dn10");
        chk("dn_09", {23'd0, tc_a, q_a}, 32'h009);
        wait_tick("dn09");
        chk("dn_08", {23'd0, tc_a, q_a}, 32'h008);
        lv_a = 8'h00; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        wait_tick("dn00");
        chk("dn_wrap", {23'd0, tc_a, q_a}, 32'h199);

        // Saturating load clears the prescaler; clr beats load
        up = 1'b1; lv_a = 8'hC5; load_a = 1'b1;
        cyc();
        load_a = 1'b0;
        chk("load_sat", 32'(q_a), 32'h95);
        repeat (3) cyc();
        chk("load_pre_cleared", {23'd0, tick_a, q_a}, 32'h095);
        cyc();
        chk("load_next_tick", {23'd0, tick_a, q_a}, 32'h196);
        lv_a = 8'h42; load_a = 1'b1; clr = 1'b1;
        cyc();
        load_a = 1'b0; clr = 1'b0;
        chk("clr_over_load", 32'(q_a), 32'h0);

        // Enable gap keeps the prescaler count
        repeat (2) cyc();
        en = 1'b0;
        repeat (3) cyc();
        chk("en_low_frozen", {23'd0, tick_a, q_a}, 32'h000);
        en = 1'b1;
        cyc();
        chk("en_resume_1", {23'd0, tick_a, q_a}, 32'h000);
        cyc();
        chk("en_resume_2", {23'd0, tick_a, q_a}, 32'h101);

        // Base-6 chain stepping every cycle
        lv_b = 12'h555; load_b = 1'b1;
        cyc();
        load_b = 1'b0;
        chk("b_load_555", 32'(q_b), 32'h555);
        cyc();
        chk("b_wrap_up", {19'd0, tc_b, q_b}, 32'h1000);
        lv_b = 12'h005; load_b = 1'b1;
        cyc();
        load_b = 1'b0;
        cyc();
        chk("b_005_010", {19'd0, tc_b, q_b}, 32'h0010);
        lv_b = 12'h000; load_b = 1'b1; up = 1'b0;
        cyc();
        load_b = 1'b0;
        cyc();
        chk("b_wrap_dn", {19'd0, tc_b, q_b}, 32'h1555);
        lv_b = 12'hF9C; load_b = 1'b1;
        cyc();
        load_b = 1'b0;
        chk("b_load_sat", 32'(q_b), 32'h555);
        en = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
